// File: rtl/four_bit_down_timer.sv
// Loadable down-counting timer with clock prescaler, pause/hold and optional auto-reload.
// done pulses one cycle on terminal count; zero is a live decode of the count.
module four_bit_down_timer #(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             pause,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             zero
);
   localparam int unsigned   PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

   typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

   state_t           state;
   logic [WIDTH-1:0] reload;
   logic [PW-1:0]    presc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         count  <= '0;
         reload <= '0;
         presc  <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (load) begin
            count  <= load_val;
            reload <= load_val;
            presc  <= '0;
            state  <= IDLE;
            busy   <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     if (count != '0) begin
                        state <= RUN;
                        presc <= '0;
                        busy  <= 1'b1;
                     end else begin
                        done <= 1'b1;
                     end
                  end
               end
               // Leaving HOLD counts in the same cycle, so each paused cycle costs exactly one.
               RUN, HOLD: begin
                  if (pause) begin
                     state <= HOLD;
                  end else begin
                     state <= RUN;
                     if (presc != PS_LAST) begin
                        presc <= presc + PW'(1);
                     end else begin
                        presc <= '0;
                        if (count > WIDTH'(1)) begin
                           count <= count - WIDTH'(1);
                        end else begin
                           done <= 1'b1;
                           if (auto_reload) begin
                              count <= reload;
                           end else begin
                              count <= '0;
                              state <= IDLE;
                              busy  <= 1'b0;
                           end
                        end
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign zero = (count == '0);

endmodule

// File: tb/tb_four_bit_down_timer.sv
// Scoreboard bench for four_bit_down_timer: one instance with PRESCALE=1, one with PRESCALE=3,
// driven from shared stimulus; each task checks the instance its scenario targets.
module tb_four_bit_down_timer;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       load = 1'b0;
   logic [3:0] load_val = 4'd0;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic       auto_reload = 1'b0;

   logic [3:0] count1, count3;
   logic       busy1, busy3, done1, done3, zero1, zero3;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       ld;
      logic [3:0] lv;
      logic       st, pa, ar, rs;
      logic [3:0] c;
      logic       b, d;
   } row_t;

   typedef struct {
      logic [3:0] count;
      logic       busy, done, zero;
   } exp_t;

   exp_t sb[$];

   four_bit_down_timer #(.WIDTH(4), .PRESCALE(1)) u_p1 (
      .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
      .pause(pause), .auto_reload(auto_reload),
      .count(count1), .busy(busy1), .done(done1), .zero(zero1)
   );

   four_bit_down_timer #(.WIDTH(4), .PRESCALE(3)) u_p3 (
      .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
      .pause(pause), .auto_reload(auto_reload),
      .count(count3), .busy(busy3), .done(done3), .zero(zero3)
   );

   always #5 clk = ~clk;

   function automatic row_t r(input int ld, input int lv, input int st, input int pa,
                              input int ar, input int rs, input int c, input int b, input int d);
      row_t x;
      x.ld = (ld != 0); x.lv = 4'(lv); x.st = (st != 0); x.pa = (pa != 0);
      x.ar = (ar != 0); x.rs = (rs != 0); x.c = 4'(c); x.b = (b != 0); x.d = (d != 0);
      return x;
   endfunction

   // Drive one cycle of stimulus and queue the state expected after the next edge.
   task automatic apply(input row_t x);
      exp_t e;
      rst = x.rs; load = x.ld; load_val = x.lv; start = x.st; pause = x.pa; auto_reload = x.ar;
      e.count = x.c; e.busy = x.b; e.done = x.d; e.zero = (x.c == 4'd0);
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      row_t t[$];
      exp_t e;
      t.push_back(r(0,0,0,0,0,1, 0,0,0));
      t.push_back(r(0,0,0,0,0,1, 0,0,0));
      foreach (t[i]) begin
         apply(t[i]); step();
         e = sb.pop_front();
         checks++;
         if ({count1, busy1, done1, zero1} !== {e.count, e.busy, e.done, e.zero}) begin
            errors++;
            $display("FAIL reset_p1[%0d]: count=%0d busy=%b done=%b zero=%b, expected count=%0d busy=%b done=%b zero=%b",
                     i, count1, busy1, done1, zero1, e.count, e.busy, e.done, e.zero);
         end
         checks++;
         if ({count3, busy3, done3, zero3} !== {e.count, e.busy, e.done, e.zero}) begin
            errors++;
            $display("FAIL reset_p3[%0d]: count=%0d busy=%b done=%b zero=%b, expected count=%0d busy=%b done=%b zero=%b",
                     i, count3, busy3, done3, zero3, e.count, e.busy, e.done, e.zero);
         end
      end
   endtask

   task automatic test_reset_mid_run();
      row_t t[$];
      exp_t e;
      t.push_back(r(1,9,0,0,0,0, 9,0,0));
      t.push_back(r(0,0,1,0,0,0, 9,1,0));
      t.push_back(r(0,0,0,0,0,0, 8,1,0));
      t.push_back(r(0,0,0,0,0,0, 7,1,0));
      t.push_back(r(0,0,0,0,0,0, 6,1,0));
      t.push_back(r(0,0,0,0,0,1, 0,0,0));
      t.push_back(r(0,0,0,0,0,0, 0,0,0));
      foreach (t[i]) begin
         apply(t[i]); step();
         e = sb.pop_front();
         checks++;
         if ({count1, busy1, done1, zero1} !== {e.count, e.busy, e.done, e.zero}) begin
            errors++;
            $display("FAIL reset_mid_run[%0d]: count=%0d busy=%b done=%b zero=%b, expected count=%0d busy=%b done=%b zero=%b",
                     i, count1, busy1, done1, zero1, e.count, e.busy, e.done, e.zero);
         end
      end
   endtask

   task automatic test_basic_countdown();
      row_t t[$];
      exp_t e;
      t.push_back(r(1,5,0,0,0,0, 5,0,0));
      t.push_back(r(0,0,1,0,0,0, 5,1,0));
      t.push_back(r(0,0,0,0,0,0, 4,1,0));
      t.push_back(r(0,0,1,0,0,0, 3,1,0));
      t.push_back(r(0,0,0,0,0,0, 2,1,0));
      t.push_back(r(0,0,0,0,0,0, 1,1,0));
      t.push_back(r(0,0,0,0,0,0, 0,0,1));
      t.push_back(r(0,0,0,0,0,0, 0,0,0));
      foreach (t[i]) begin
         apply(t[i]); step();
         e = sb.pop_front();
         checks++;
         if ({count1, busy1, done1, zero1} !== {e.count, e.busy, e.done, e.zero}) begin
            errors++;
            $display("FAIL basic[%0d]: count=%0d busy=%b done=%b zero=%b, expected count=%0d busy=%b done=%b zero=%b",
                     i, count1, busy1, done1, zero1, e.count, e.busy, e.done, e.zero);
         end
      end
   endtask

   task automatic test_prescale_pause();
      row_t t[$];
      exp_t e;
      t.push_back(r(1,2,0,0,0,0, 2,0,0));
      t.push_back(r(0,0,1,0,0,0, 2,1,0));
      t.push_back(r(0,0,0,0,0,0, 2,1,0));
      t.push_back(r(0,0,0,0,0,0, 2,1,0));
      t.push_back(r(0,0,0,0,0,0, 1,1,0));
      t.push_back(r(0,0,0,0,0,0, 1,1,0));
      for (int k = 0; k < 4; k++) t.push_back(r(0,0,0,1,0,0, 1,1,0));
      t.push_back(r(0,0,0,0,0,0, 1,1,0));
      t.push_back(r(0,0,0,0,0,0, 0,0,1));
      t.push_back(r(0,0,0,0,0,0, 0,0,0));
      foreach (t[i]) begin
         apply(t[i]); step();
         e = sb.pop_front();
         checks++;
         if ({count3, busy3, done3, zero3} !== {e.count, e.busy, e.done, e.zero}) begin
            errors++;
            $display("FAIL prescale_pause[%0d]: count=%0d busy=%b done=%b zero=%b, expected count=%0d busy=%b done=%b zero=%b",
                     i, count3, busy3, done3, zero3, e.count, e.busy, e.done, e.zero);
         end
      end
   endtask

   task automatic test_auto_reload();
      row_t t[$];
      exp_t e;
      t.push_back(r(1,3,0,0,0,0, 3,0,0));
      t.push_back(r(0,0,1,0,1,0, 3,1,0));
      t.push_back(r(0,0,0,0,1,0, 2,1,0));
      t.push_back(r(0,0,0,0,1,0, 1,1,0));
      t.push_back(r(0,0,0,0,1,0, 3,1,1));
      t.push_back(r(0,0,0,0,1,0, 2,1,0));
      t.push_back(r(0,0,0,0,1,0, 1,1,0));
      t.push_back(r(0,0,0,0,1,0, 3,1,1));
      t.push_back(r(0,0,0,0,1,0, 2,1,0));
      t.push_back(r(0,0,0,0,0,0, 1,1,0));
      t.push_back(r(0,0,0,0,0,0, 0,0,1));
      t.push_back(r(0,0,0,0,0,0, 0,0,0));
      foreach (t[i]) begin
         apply(t[i]); step();
         e = sb.pop_front();
         checks++;
         if ({count1, busy1, done1, zero1} !== {e.count, e.busy, e.done, e.zero}) begin
            errors++;
            $display("FAIL auto_reload[%0d]: count=%0d busy=%b done=%b zero=%b, expected count=%0d busy=%b done=%b zero=%b",
                     i, count1, busy1, done1, zero1, e.count, e.busy, e.done, e.zero);
         end
      end
   endtask

   task automatic test_zero_and_abort();
      row_t t[$];
      exp_t e;
      t.push_back(r(1,0,0,0,0,0, 0,0,0));
      t.push_back(r(0,0,1,0,0,0, 0,0,1));
      t.push_back(r(0,0,0,0,0,0, 0,0,0));
      t.push_back(r(1,7,0,0,0,0, 7,0,0));
      t.push_back(r(0,0,1,0,0,0, 7,1,0));
      t.push_back(r(0,0,0,0,0,0, 6,1,0));
      t.push_back(r(1,4,0,0,0,0, 4,0,0));
      t.push_back(r(0,0,0,0,0,0, 4,0,0));
      foreach (t[i]) begin
         apply(t[i]); step();
         e = sb.pop_front();
         checks++;
         if ({count1, busy1, done1, zero1} !== {e.count, e.busy, e.done, e.zero}) begin
            errors++;
            $display("FAIL zero_abort[%0d]: count=%0d busy=%b done=%b zero=%b, expected count=%0d busy=%b done=%b zero=%b",
                     i, count1, busy1, done1, zero1, e.count, e.busy, e.done, e.zero);
         end
      end
   endtask

   task automatic test_simultaneous();
      row_t t[$];
      exp_t e;
      t.push_back(r(1,4,0,0,0,0, 4,0,0));
      t.push_back(r(1,6,1,0,0,0, 6,0,0));
      t.push_back(r(0,0,0,0,0,0, 6,0,0));
      t.push_back(r(1,2,0,0,0,0, 2,0,0));
      t.push_back(r(0,0,1,0,0,0, 2,1,0));
      t.push_back(r(0,0,0,0,0,0, 1,1,0));
      t.push_back(r(1,5,0,0,0,0, 5,0,0));
      t.push_back(r(1,2,0,0,0,0, 2,0,0));
      t.push_back(r(0,0,1,0,0,0, 2,1,0));
      t.push_back(r(0,0,0,0,0,0, 1,1,0));
      t.push_back(r(0,0,0,1,0,0, 1,1,0));
      t.push_back(r(0,0,0,1,0,0, 1,1,0));
      t.push_back(r(0,0,0,0,0,0, 0,0,1));
      t.push_back(r(0,0,0,0,0,0, 0,0,0));
      foreach (t[i]) begin
         apply(t[i]); step();
         e = sb.pop_front();
         checks++;
         if ({count1, busy1, done1, zero1} !== {e.count, e.busy, e.done, e.zero}) begin
            errors++;
            $display("FAIL simultaneous[%0d]: count=%0d busy=%b done=%b zero=%b, expected count=%0d busy=%b done=%b zero=%b",
                     i, count1, busy1, done1, zero1, e.count, e.busy, e.done, e.zero);
         end
      end
   endtask

   task automatic test_back_to_back();
      row_t t[$];
      exp_t e;
      t.push_back(r(1,1,0,0,0,0, 1,0,0));
      t.push_back(r(0,0,1,0,1,0, 1,1,0));
      t.push_back(r(0,0,0,0,1,0, 1,1,1));
      t.push_back(r(0,0,0,0,1,0, 1,1,1));
      t.push_back(r(0,0,0,0,1,0, 1,1,1));
      t.push_back(r(1,0,0,0,1,0, 0,0,0));
      t.push_back(r(0,0,0,0,0,0, 0,0,0));
      foreach (t[i]) begin
         apply(t[i]); step();
         e = sb.pop_front();
         checks++;
         if ({count1, busy1, done1, zero1} !== {e.count, e.busy, e.done, e.zero}) begin
            errors++;
            $display("FAIL back_to_back[%0d]: count=%0d busy=%b done=%b zero=%b, expected count=%0d busy=%b done=%b zero=%b",
                     i, count1, busy1, done1, zero1, e.count, e.busy, e.done, e.zero);
         end
      end
   endtask

   initial begin
      test_reset();
      test_reset_mid_run();
      test_basic_countdown();
      test_prescale_pause();
      test_auto_reload();
      test_zero_and_abort();
      test_simultaneous();
      test_back_to_back();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
